// File: rtl/data_island_packet_serializer.sv
// Serialises one buffered info-frame packet (header + 4 subpackets + BCH parity) over a 32-beat data-island slot.
// Optional slot statistics outputs are enabled by defining DATA_ISLAND_SERIALIZER_STATS_EN.
module data_island_packet_serializer #(
  parameter logic [7:0] ECC_POLY = 8'h83
) (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      header,
  input  logic [3:0][55:0] sub,
  input  logic             island_en,
  output logic [8:0]       packet_data,
  output logic             packet_start,
  output logic             packet_is_null
`ifdef DATA_ISLAND_SERIALIZER_STATS_EN
  ,
  output logic [15:0]      packets_sent,
  output logic [7:0]       aborts
`endif
);

  function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
    return {1'b0, e[7:1]} ^ ((e[0] ^ b) ? ECC_POLY : 8'h00);
  endfunction

  logic [4:0]       r_count;
  logic             r_buf_full;
  logic [23:0]      r_buf_hdr;
  logic [3:0][55:0] r_buf_sub;
  logic [23:0]      r_hdr;
  logic [3:0][55:0] r_sub;
  logic             r_null;
  logic [7:0]       r_ecc_h;
  logic [3:0][7:0]  r_ecc_s;
  logic [8:0]       r_data;
  logic             r_start;
  logic             r_is_null;

  logic             w_slot_start;
  logic             w_accept;
  logic [23:0]      w_hdr;
  logic [3:0][55:0] w_sub;
  logic             w_null;
  logic [8:0]       w_beat;
  logic [7:0]       w_ecc_h_nxt;
  logic [3:0][7:0]  w_ecc_s_nxt;
  logic [7:0]       w_ecc_s_base;
  logic             w_b0, w_b1;

  assign w_slot_start = island_en && (r_count == 5'd0);
  assign w_accept     = in_valid && !r_buf_full;
  assign in_ready     = !r_buf_full;

  // Beat 0 is produced in the same cycle the working registers load, so
  // bypass straight from the buffer (or zeros for a null packet).
  assign w_hdr  = w_slot_start ? (r_buf_full ? r_buf_hdr : '0) : r_hdr;
  assign w_sub  = w_slot_start ? (r_buf_full ? r_buf_sub : '0) : r_sub;
  assign w_null = w_slot_start ? !r_buf_full : r_null;

  always_comb begin
    w_beat       = '0;
    w_ecc_h_nxt  = r_ecc_h;
    w_ecc_s_nxt  = r_ecc_s;
    w_ecc_s_base = '0;
    w_b0         = 1'b0;
    w_b1         = 1'b0;
    if (r_count < 5'd24) begin
      w_beat[0]   = w_hdr[r_count];
      w_ecc_h_nxt = ecc_step((r_count == 5'd0) ? 8'h00 : r_ecc_h, w_hdr[r_count]);
    end else begin
      w_beat[0] = r_ecc_h[r_count[2:0]];
    end
    for (int i = 0; i < 4; i++) begin
      if (r_count < 5'd28) begin
        w_b0           = w_sub[i][{r_count, 1'b0}];
        w_b1           = w_sub[i][{r_count, 1'b1}];
        w_ecc_s_base   = (r_count == 5'd0) ? 8'h00 : r_ecc_s[i];
        w_ecc_s_nxt[i] = ecc_step(ecc_step(w_ecc_s_base, w_b0), w_b1);
      end else begin
        w_b0 = r_ecc_s[i][{r_count[1:0], 1'b0}];
        w_b1 = r_ecc_s[i][{r_count[1:0], 1'b1}];
      end
      w_beat[1+i] = w_b0;
      w_beat[5+i] = w_b1;
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_buf_full <= 1'b0;
      r_buf_hdr  <= '0;
      r_buf_sub  <= '0;
      r_hdr      <= '0;
      r_sub      <= '0;
      r_null     <= 1'b0;
      r_ecc_h    <= '0;
      r_ecc_s    <= '0;
      r_data     <= '0;
      r_start    <= 1'b0;
      r_is_null  <= 1'b0;
    end else begin
      r_count <= island_en ? r_count + 5'd1 : 5'd0;
      if (w_accept) begin
        r_buf_hdr  <= header;
        r_buf_sub  <= sub;
        r_buf_full <= 1'b1;
      end else if (w_slot_start) begin
        r_buf_full <= 1'b0;
      end
      if (island_en) begin
        r_hdr     <= w_hdr;
        r_sub     <= w_sub;
        r_null    <= w_null;
        r_ecc_h   <= w_ecc_h_nxt;
        r_ecc_s   <= w_ecc_s_nxt;
        r_data    <= w_beat;
        r_start   <= w_slot_start;
        r_is_null <= w_null;
      end else begin
        // Leaving the island drops any in-flight packet; the buffer survives.
        r_hdr     <= '0;
        r_sub     <= '0;
        r_null    <= 1'b0;
        r_ecc_h   <= '0;
        r_ecc_s   <= '0;
        r_data    <= '0;
        r_start   <= 1'b0;
        r_is_null <= 1'b0;
      end
    end
  end

  assign packet_data    = r_data;
  assign packet_start   = r_start;
  assign packet_is_null = r_is_null;

`ifdef DATA_ISLAND_SERIALIZER_STATS_EN
  logic [15:0] r_sent;
  logic [7:0]  r_aborts;

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_sent   <= '0;
      r_aborts <= '0;
    end else begin
      if (island_en && r_count == 5'd31 && !r_null)
        r_sent <= r_sent + 16'd1;
      // A nonzero count with island_en low means the slot was cut short.
      if (!island_en && r_count != 5'd0)
        r_aborts <= r_aborts + 8'd1;
    end
  end

  assign packets_sent = r_sent;
  assign aborts       = r_aborts;
`endif

endmodule

// File: tb/tb_data_island_packet_serializer.sv
// Directed bench for data_island_packet_serializer with a beat scoreboard built from a bit-serial BCH model.
module tb_data_island_packet_serializer;

  logic             clk_pixel;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [23:0]      header;
  logic [3:0][55:0] sub;
  logic             island_en;
  logic [8:0]       packet_data;
  logic             packet_start;
  logic             packet_is_null;
`ifdef DATA_ISLAND_SERIALIZER_STATS_EN
  logic [15:0]      packets_sent;
  logic [7:0]       aborts;
`endif

  data_island_packet_serializer dut (
    .clk_pixel      (clk_pixel),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .header         (header),
    .sub            (sub),
    .island_en      (island_en),
    .packet_data    (packet_data),
    .packet_start   (packet_start),
    .packet_is_null (packet_is_null)
`ifdef DATA_ISLAND_SERIALIZER_STATS_EN
    ,
    .packets_sent   (packets_sent),
    .aborts         (aborts)
`endif
  );

  initial begin
    clk_pixel = 1'b0;
    forever #5 clk_pixel = ~clk_pixel;
  end

  typedef struct packed {
    logic [8:0] d;
    logic       st;
    logic       nl;
  } beat_t;

  beat_t q[$];
  int    total = 0;
  int    bad   = 0;
  logic  obs_b0 [32];
  logic [7:0] ecc_obs;

  function automatic logic [7:0] bstep(input logic [7:0] e, input logic b);
    bstep = {1'b0, e[7:1]} ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected 32 beats of one slot: parity computed over whole fields first.
  task automatic push_slot(input logic [23:0] h, input logic [3:0][55:0] s, input logic nul);
    logic [7:0]      eh;
    logic [3:0][7:0] es;
    beat_t           b;
    eh = 8'h00;
    es = '0;
    for (int k = 0; k < 24; k++) eh = bstep(eh, h[k]);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 56; k++) es[i] = bstep(es[i], s[i][k]);
    for (int n = 0; n < 32; n++) begin
      b.d[0] = (n < 24) ? h[n] : eh[n-24];
      for (int i = 0; i < 4; i++) begin
        b.d[1+i] = (n < 28) ? s[i][2*n]   : es[i][2*(n-28)];
        b.d[5+i] = (n < 28) ? s[i][2*n+1] : es[i][2*(n-28)+1];
      end
      b.st = (n == 0);
      b.nl = nul;
      q.push_back(b);
    end
  endtask

  task automatic check_beats(input int cnt, input int first);
    beat_t e;
    for (int k = 0; k < cnt; k++) begin
      @(posedge clk_pixel); #1;
      if (q.size() == 0) begin
        chk("scoreboard_empty", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk($sformatf("beat%0d_data", first + k), 64'(packet_data), 64'(e.d));
        chk($sformatf("beat%0d_start", first + k), 64'(packet_start), 64'(e.st));
        chk($sformatf("beat%0d_null", first + k), 64'(packet_is_null), 64'(e.nl));
        if (first + k < 32) obs_b0[first + k] = packet_data[0];
      end
    end
  endtask

  // Present a packet and wait (bounded) for the handshake to complete.
  task automatic load(input logic [23:0] h, input logic [3:0][55:0] s, input logic keep);
    int waited;
    in_valid = 1'b1;
    header   = h;
    sub      = s;
    waited   = 0;
    while (!in_ready && waited < 40) begin
      @(posedge clk_pixel); #1;
      waited++;
    end
    if (!in_ready) chk("load_timeout", 64'd1, 64'd0);
    @(posedge clk_pixel); #1;
    if (!keep) in_valid = 1'b0;
    chk("rdy_after_accept", 64'(in_ready), 64'd0);
  endtask

  logic [3:0][55:0] s0, sa, sb, sc, sd;

  initial begin
    reset = 1'b1; in_valid = 1'b0; header = '0; sub = '0; island_en = 1'b0;
    s0 = '0;
    repeat (2) @(posedge clk_pixel);
    #1;
    chk("rst_data", 64'(packet_data), 64'd0);
    chk("rst_start", 64'(packet_start), 64'd0);
    chk("rst_null", 64'(packet_is_null), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;

    // Idle slot: null packet
    push_slot(24'h0, s0, 1'b1);
    island_en = 1'b1;
    check_beats(32, 0);
    island_en = 1'b0;
    @(posedge clk_pixel); #1;
    chk("idle_data", 64'(packet_data), 64'd0);

    // Single header bit: header parity byte must be 0x4A
    load(24'h000001, s0, 1'b0);
    push_slot(24'h000001, s0, 1'b0);
    island_en = 1'b1;
    check_beats(32, 0);
    island_en = 1'b0;
    for (int n = 0; n < 8; n++) ecc_obs[n] = obs_b0[24+n];
    chk("hdr_ecc_4a", 64'(ecc_obs), 64'h4A);

    // Mixed header with sub0 = 1
    sa = '0; sa[0] = 56'h01;
    load(24'h190183, sa, 1'b0);
    push_slot(24'h190183, sa, 1'b0);
    island_en = 1'b1;
    check_beats(32, 0);
    island_en = 1'b0;

    // Back-to-back packets with in_valid held
    sa[0] = 56'h0123456789ABCD; sa[1] = 56'hFEDCBA98765432;
    sa[2] = 56'h5A5A5A5A5A5A5A; sa[3] = 56'h80000000000001;
    sb[0] = 56'hDEADBEEFCAFE12; sb[1] = 56'h00FF00FF00FF00;
    sb[2] = 56'h13579BDF02468A; sb[3] = 56'hFFFFFFFFFFFFFF;
    load(24'h123456, sa, 1'b1);
    header = 24'hA5C3E1; sub = sb;
    @(posedge clk_pixel); #1;
    chk("b2b_ready_low", 64'(in_ready), 64'd0);
    push_slot(24'h123456, sa, 1'b0);
    push_slot(24'hA5C3E1, sb, 1'b0);
    island_en = 1'b1;
    check_beats(1, 0);
    chk("b2b_ready_rise", 64'(in_ready), 64'd1);
    check_beats(1, 1);
    chk("b2b_second_accepted", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    check_beats(30, 2);
    check_beats(32, 0);
    island_en = 1'b0;

    // Abort at count 10 from a clean reset; buffered packet survives
    reset = 1'b1;
    @(posedge clk_pixel); #1;
    reset = 1'b0;
    sc = '0; sc[3] = 56'h00000000ABCDEF;
    sd = '0; sd[1] = 56'h11223344556677;
    load(24'h0F0F0F, sc, 1'b0);
    push_slot(24'h0F0F0F, sc, 1'b0);
    island_en = 1'b1;
    check_beats(1, 0);
    in_valid = 1'b1; header = 24'h778899; sub = sd;
    check_beats(1, 1);
    in_valid = 1'b0;
    check_beats(8, 2);
    island_en = 1'b0;
    q.delete();
    @(posedge clk_pixel); #1;
    chk("abort_data", 64'(packet_data), 64'd0);
    chk("abort_null", 64'(packet_is_null), 64'd0);
    chk("abort_buf_kept", 64'(in_ready), 64'd0);
`ifdef DATA_ISLAND_SERIALIZER_STATS_EN
    chk("abort_count", 64'(aborts), 64'd1);
    chk("abort_sent", 64'(packets_sent), 64'd0);
`endif
    push_slot(24'h778899, sd, 1'b0);
    island_en = 1'b1;
    check_beats(32, 0);
    island_en = 1'b0;
`ifdef DATA_ISLAND_SERIALIZER_STATS_EN
    @(posedge clk_pixel); #1;
    chk("sent_after_slot", 64'(packets_sent), 64'd1);
    chk("aborts_stable", 64'(aborts), 64'd1);
`endif

    // Reset during beat 15 loses both working and buffered packets
    load(24'hC0FFEE, sa, 1'b0);
    push_slot(24'hC0FFEE, sa, 1'b0);
    island_en = 1'b1;
    check_beats(1, 0);
    in_valid = 1'b1; header = 24'h445566; sub = sb;
    check_beats(1, 1);
    in_valid = 1'b0;
    check_beats(14, 2);
    reset = 1'b1;
    island_en = 1'b0;
    #1;
    q.delete();
    chk("midrst_data", 64'(packet_data), 64'd0);
    chk("midrst_start", 64'(packet_start), 64'd0);
    chk("midrst_null", 64'(packet_is_null), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
`ifdef DATA_ISLAND_SERIALIZER_STATS_EN
    chk("midrst_sent", 64'(packets_sent), 64'd0);
`endif
    @(posedge clk_pixel); #1;
    reset = 1'b0;
    push_slot(24'h0, s0, 1'b1);
    island_en = 1'b1;
    check_beats(32, 0);
    island_en = 1'b0;
    @(posedge clk_pixel); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_island_packet_serializer.md
Name: data_island_packet_serializer

Overview:
- Consumes one assembled info-frame packet (24-bit header plus four 56-bit subpackets) from an upstream frame generator through a valid/ready handshake.
- Buffers one packet and serialises it over a 32-cycle data-island packet slot, appending the BCH parity bytes for the header and each subpacket.
- Emits 9 bits per pixel clock to the TERC4 channel mapper downstream.
- When a slot opens and no packet is buffered, sends a null packet.

Parameters:
- ECC_POLY, 8'h83: reflected feedback taps of the BCH generator G(x)=1+x^6+x^7+x^8; step is ecc=(ecc>>1)^((ecc[0]^bit)?ECC_POLY:0).

Ports:
- clk_pixel  input  1  pixel clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  header/sub hold a packet to accept.
- in_ready  output  1  one-entry buffer empty; a transfer occurs when in_valid&in_ready.
- header  input  24  packet header HB2:HB1:HB0, HB0 in bits [7:0].
- sub  input  4x56  subpacket i, PB0 of each in bits [7:0].
- island_en  input  1  high for whole packet slots (multiples of 32 cycles) during a data island.
- packet_data  output  9  bit0 = header/ECC bit; bits[4:1] = even bit of sub0..3; bits[8:5] = odd bit of sub0..3.
- packet_start  output  1  one-cycle pulse aligned with the packet_data beat of count 0.
- packet_is_null  output  1  high for all 32 beats of a null packet.

Behaviour:
- Reset values: count=0, buffer empty, in_ready=1, packet_data=0, packet_start=0, packet_is_null=0, ECC registers=0.
- Slot counter: count[4:0].
  - While island_en=1, count increments each cycle, wrapping 31->0.
  - While island_en=0, count forced to 0.
- Buffer: one entry; in_ready = ~buf_full.
  - Accept: header/sub latched on in_valid&in_ready.
- Slot start (island_en=1 && count==0):
  - If buf_full: buffer moves to the working registers and buf_full clears.
  - If buffer is empty: working registers load all zeros and the null flag is set.
  - Accept and slot start in the same cycle with the buffer empty: the packet goes into the buffer; the current slot sends null.
- Beat n (count=n); packet_data registered, latency 1 cycle after count=n.
  - n<24: bit0 = header[n], ECC_H stepped with that bit; at n=0 the step starts from 0.
  - n>=24: bit0 = ECC_H[n-24]; the ECC value is frozen after beat 23.
  - n<28: bit(1+i) = sub[i][2n] and bit(5+i) = sub[i][2n+1]. ECC_S[i] stepped twice per cycle, even bit first.
  - n>=28: bits carry ECC_S[i][2(n-28)] and [2(n-28)+1].
- packet_start = registered (island_en && count==0).
- packet_is_null: registered null flag, valid with each beat.
- island_en falls mid-slot: slot aborted.
  - Working packet discarded, not resent.
  - Next cycle packet_data=0 and packet_is_null=0.
  - Buffer contents untouched.
- island_en=0: packet_data=0.
- Reset mid-slot: all state to reset values immediately; a buffered packet is lost.
- Width rule: ECC registers are exactly 8 bits; no carry.

Optional Feature:
- Macro: DATA_ISLAND_SERIALIZER_STATS_EN.
- With the macro, two extra outputs:
  - packets_sent [15:0]: counts completed non-null slots, incremented on beat 31.
  - aborts [7:0]: counts slots cut short by island_en falling.
  - Both counters wrap and reset to 0.
- Without the macro: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, island_en=1 for 32 cycles, no in_valid.
  - packet_start pulses once; packet_is_null=1 on all 32 beats; packet_data=9'h000 on all beats.
- Load header=24'h000001, sub all 0, then a slot.
  - Beat0 bit0=1; beats1-23 bit0=0.
  - Beats24-31 bit0 = 0x4A LSB-first (0,1,0,1,0,0,1,0); bits[8:1]=0 throughout.
- Load header=24'h190183, sub0=56'h01, others 0.
  - Beat0 packet_data[1]=1; the bench checks every beat's bits against a bit-serial model using poly 0x83.
  - packet_is_null=0.
- in_valid held with two different packets back-to-back.
  - in_ready drops after the first accept and rises the cycle after the slot-start beat.
  - The second packet is transmitted in the next slot.
- island_en dropped at count=10.
  - packet_data=0 the next cycle; the next slot starts at count 0.
  - With the stats macro, aborts=1 and packets_sent=0.
- Assert reset during beat 15.
  - All outputs 0 immediately; in_ready=1.
  - The following slot sends null.
